// File: rtl/store_buffer_pkg.sv
// Shared types and encodings for the store buffer.
// Merge helper is used only when STORE_MERGE_EN is defined.
package store_buffer_pkg;

  localparam int OP_SW  = 0;
  localparam int OP_SH  = 1;
  localparam int OP_SB  = 2;
  localparam int OP_SWR = 3;
  localparam int OP_SWL = 4;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] data;
  } sb_entry_t;

  function automatic sb_entry_t merge_entry(sb_entry_t o, sb_entry_t n);
    sb_entry_t m;
    m = o;
    for (int b = 0; b < 4; b++) begin
      if (n.strb[b]) m.data[8*b +: 8] = n.data[8*b +: 8];
    end
    m.strb = o.strb | n.strb;
    m.size = SZ_W;
    m.addr = {o.addr[31:2], 2'b00};
    return m;
  endfunction

endpackage

// File: rtl/store_align.sv
// Store formatter: op/addr/rt to lane-aligned {addr, size, strb, data}.
// Little-endian lanes; swl/swr always issue word-aligned addresses.
module store_align
  import store_buffer_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] rt,
  output sb_entry_t   ent
);

  logic [1:0] a;
  assign a = addr[1:0];

  always_comb begin
    ent = '0;
    ent.addr = addr;
    unique case (1'b1)
      op[OP_SB]: begin
        ent.size = SZ_B;
        ent.strb = 4'b0001 << a;
        ent.data = {4{rt[7:0]}};
      end
      op[OP_SH]: begin
        ent.size = SZ_H;
        ent.strb = a[1] ? 4'b1100 : 4'b0011;
        ent.data = {2{rt[15:0]}};
      end
      op[OP_SW]: begin
        ent.size = SZ_W;
        ent.strb = 4'b1111;
        ent.data = rt;
      end
      op[OP_SWL]: begin
        ent.size = SZ_W;
        ent.addr = {addr[31:2], 2'b00};
        case (a)
          2'd0: begin ent.strb = 4'b0001; ent.data = {24'b0, rt[31:24]}; end
          2'd1: begin ent.strb = 4'b0011; ent.data = {16'b0, rt[31:16]}; end
          2'd2: begin ent.strb = 4'b0111; ent.data = {8'b0, rt[31:8]}; end
          default: begin ent.strb = 4'b1111; ent.data = rt; end
        endcase
      end
      op[OP_SWR]: begin
        ent.size = SZ_W;
        ent.addr = {addr[31:2], 2'b00};
        case (a)
          2'd0: begin ent.strb = 4'b1111; ent.data = rt; end
          2'd1: begin ent.strb = 4'b1110; ent.data = {rt[23:0], 8'b0}; end
          2'd2: begin ent.strb = 4'b1100; ent.data = {rt[15:0], 16'b0}; end
          default: begin ent.strb = 4'b1000; ent.data = {rt[7:0], 24'b0}; end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Store queue draining to data SRAM, one transaction outstanding.
// Define STORE_MERGE_EN to coalesce same-word stores into the tail entry.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        st_valid,
  input  logic [4:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  output logic        stallreq_for_store,
  input  logic        ld_check_valid,
  input  logic [31:0] ld_check_addr,
  output logic        ld_conflict,
  output logic        sb_empty,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  sb_entry_t        q [DEPTH];
  sb_entry_t        new_e;
  logic [PTR_W-1:0] head, tail, last;
  logic [PTR_W:0]   count, count_n;
  logic [1:0]       state, state_n;
  logic             take, hit, alloc, merge, pop, full, busy;

  store_align u_align (
    .op   (st_op),
    .addr (st_addr),
    .rt   (st_data),
    .ent  (new_e)
  );

  assign last = tail - PTR_W'(1);
  assign full = count == FULL;
  assign busy = state != ST_IDLE;
  assign take = st_valid & ~flush & (|st_op);
  assign pop  = (state == ST_WAIT) & data_sram_data_ok;

`ifdef STORE_MERGE_EN
  logic [4:0] tail_op;
  // the head is frozen once it is (or is about to be) on the bus
  assign hit = (count != '0) & ~((last == head) & busy)
             & (tail_op == st_op)
             & (q[last].addr[31:2] == st_addr[31:2]);
`else
  assign hit = 1'b0;
`endif

  assign merge = take & hit;
  assign alloc = take & ~hit & ~full;
  assign count_n = count + (PTR_W+1)'(alloc) - (PTR_W+1)'(pop);

  assign st_ready = ~full | hit;
  assign stallreq_for_store = st_valid & ~st_ready;
  assign sb_empty = (count == '0) & ~busy;

  assign data_sram_req   = state == ST_REQ;
  assign data_sram_wr    = 1'b1;
  assign data_sram_addr  = busy ? q[head].addr : '0;
  assign data_sram_size  = busy ? q[head].size : '0;
  assign data_sram_wstrb = busy ? q[head].strb : '0;
  assign data_sram_wdata = busy ? q[head].data : '0;

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (count != '0) state_n = ST_REQ;
      ST_REQ:  if (data_sram_addr_ok) state_n = ST_WAIT;
      ST_WAIT: if (data_sram_data_ok)
                 state_n = (count_n != '0) ? ST_REQ : ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PTR_W'(PTR_W'(i) - head)} < count)
          && (q[i].addr[31:2] == ld_check_addr[31:2]))
        ld_conflict = 1'b1;
    end
    ld_conflict = ld_conflict & ld_check_valid;
  end

  logic unused_bits;
  assign unused_bits = ^ld_check_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= ST_IDLE;
    end else begin
      state <= state_n;
      count <= count_n;
      if (alloc) tail <= tail + PTR_W'(1);
      if (pop) head <= head + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) q[tail] <= new_e;
`ifdef STORE_MERGE_EN
    if (merge) q[last] <= merge_entry(q[last], new_e);
`endif
  end

`ifdef STORE_MERGE_EN
  always_ff @(posedge clk) begin
    if (rst) tail_op <= '0;
    else if (take & (alloc | merge)) tail_op <= st_op;
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_store_buffer;

  logic        clk = 0;
  logic        rst, flush, st_valid;
  logic [4:0]  st_op;
  logic [31:0] st_addr, st_data;
  logic        st_ready, stallreq_for_store;
  logic        ld_check_valid;
  logic [31:0] ld_check_addr;
  logic        ld_conflict, sb_empty;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;

  int tests = 0;
  int fails = 0;

  localparam logic [4:0] SW = 5'b00001, SH = 5'b00010, SB = 5'b00100;
  localparam logic [4:0] SWR = 5'b01000, SWL = 5'b10000;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] data;
  } ref_t;

  ref_t mq[$];

  store_buffer dut (
    .clk(clk), .rst(rst), .flush(flush), .st_valid(st_valid),
    .st_op(st_op), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .stallreq_for_store(stallreq_for_store),
    .ld_check_valid(ld_check_valid), .ld_check_addr(ld_check_addr),
    .ld_conflict(ld_conflict), .sb_empty(sb_empty),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; st_valid = 0; st_op = 0; st_addr = 0; st_data = 0;
    ld_check_valid = 0; ld_check_addr = 0;
    data_sram_addr_ok = 0; data_sram_data_ok = 0;
  endtask

  task automatic push(input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] d);
    st_valid = 1; st_op = op; st_addr = a; st_data = d;
    tick();
    st_valid = 0; st_op = 0;
  endtask

  function automatic ref_t ref_align(logic [4:0] op, logic [31:0] a,
                                     logic [31:0] rt);
    ref_t e;
    int o;
    o = int'(a[1:0]);
    e.addr = a;
    if (op == SB) begin
      e.size = 0; e.strb = 4'(1 << o); e.data = {4{rt[7:0]}};
    end else if (op == SH) begin
      e.size = 1; e.strb = (o >= 2) ? 4'hC : 4'h3; e.data = {2{rt[15:0]}};
    end else if (op == SW) begin
      e.size = 2; e.strb = 4'hF; e.data = rt;
    end else if (op == SWL) begin
      e.size = 2; e.addr = {a[31:2], 2'b00};
      e.strb = 4'((1 << (o + 1)) - 1);
      e.data = rt >> (8 * (3 - o));
    end else begin
      e.size = 2; e.addr = {a[31:2], 2'b00};
      e.strb = 4'((15 << o) & 15);
      e.data = rt << (8 * o);
    end
    return e;
  endfunction

  task automatic drain_one(output logic [31:0] a, output logic [1:0] sz,
                           output logic [3:0] sb, output logic [31:0] d,
                           output bit to);
    int n;
    n = 0;
    to = 0;
    while (data_sram_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (data_sram_req !== 1'b1) to = 1;
    a = data_sram_addr; sz = data_sram_size;
    sb = data_sram_wstrb; d = data_sram_wdata;
    data_sram_addr_ok = 1; tick(); data_sram_addr_ok = 0;
    data_sram_data_ok = 1; tick(); data_sram_data_ok = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; tick(); tick();
    tests++;
    if ({data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
         data_sram_wstrb, data_sram_wdata, st_ready, sb_empty, ld_conflict}
        !== {1'b0, 1'b1, 2'b0, 32'b0, 4'b0, 32'b0, 1'b1, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset: req=%b sz=%0d addr=%h strb=%b wd=%h rdy=%b emp=%b",
               data_sram_req, data_sram_size, data_sram_addr,
               data_sram_wstrb, data_sram_wdata, st_ready, sb_empty);
    end
    rst = 0; tick();
  endtask

  task automatic test_sb();
    push(SB, 32'h1003, 32'h0000_00AB);
    tests++;
    if (sb_empty !== 1'b0) begin
      fails++; $display("FAIL sb_empty_after_push: got %b want 0", sb_empty);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({data_sram_req, data_sram_addr, data_sram_size, data_sram_wstrb,
           data_sram_wdata} !== {1'b1, 32'h1003, 2'd0, 4'b1000,
                                 32'hABAB_ABAB}) begin
        fails++;
        $display("FAIL sb_req_hold%0d: req=%b addr=%h sz=%0d strb=%b wd=%h",
                 i, data_sram_req, data_sram_addr, data_sram_size,
                 data_sram_wstrb, data_sram_wdata);
      end
      tick();
    end
    data_sram_addr_ok = 1; tick(); data_sram_addr_ok = 0;
    tests++;
    if ({data_sram_req, sb_empty} !== 2'b00) begin
      fails++; $display("FAIL sb_wait: req/empty=%b want 00",
                        {data_sram_req, sb_empty});
    end
    data_sram_data_ok = 1; tick(); data_sram_data_ok = 0;
    tests++;
    if ({data_sram_req, sb_empty} !== 2'b01) begin
      fails++; $display("FAIL sb_done: req/empty=%b want 01",
                        {data_sram_req, sb_empty});
    end
  endtask

  task automatic test_swl_swr();
    logic [31:0] a, d;
    logic [1:0] sz;
    logic [3:0] sb;
    bit to;
    push(SWL, 32'h2001, 32'h1122_3344);
    push(SWR, 32'h2001, 32'h1122_3344);
    drain_one(a, sz, sb, d, to);
    tests++;
    if (to || {a, sz, sb, d} !== {32'h2000, 2'd2, 4'b0011, 32'h0000_1122}) begin
      fails++;
      $display("FAIL swl: to=%b addr=%h sz=%0d strb=%b wd=%h", to, a, sz, sb, d);
    end
    drain_one(a, sz, sb, d, to);
    tests++;
    if (to || {a, sz, sb, d} !== {32'h2000, 2'd2, 4'b1110, 32'h2233_4400}) begin
      fails++;
      $display("FAIL swr: to=%b addr=%h sz=%0d strb=%b wd=%h", to, a, sz, sb, d);
    end
  endtask

  task automatic test_full();
    logic [31:0] a, d;
    logic [1:0] sz;
    logic [3:0] sb;
    bit to;
    for (int i = 0; i < 4; i++) begin
      st_valid = 1; st_op = SW;
      st_addr = 32'h100 + 32'(4 * i); st_data = 32'hA0 + 32'(i);
      tick();
    end
    st_addr = 32'h110; st_data = 32'hA4;
    #1;
    tests++;
    if ({st_ready, stallreq_for_store} !== 2'b01) begin
      fails++; $display("FAIL full_stall: rdy/stall=%b want 01",
                        {st_ready, stallreq_for_store});
    end
    data_sram_addr_ok = 1; tick(); data_sram_addr_ok = 0;
    tests++;
    if (st_ready !== 1'b0) begin
      fails++; $display("FAIL full_wait: rdy=%b want 0", st_ready);
    end
    data_sram_data_ok = 1; tick(); data_sram_data_ok = 0;
    tests++;
    if ({st_ready, stallreq_for_store} !== 2'b10) begin
      fails++; $display("FAIL full_freed: rdy/stall=%b want 10",
                        {st_ready, stallreq_for_store});
    end
    tick();
    st_valid = 0; st_op = 0;
    tests++;
    if (st_ready !== 1'b0) begin
      fails++; $display("FAIL full_refill: rdy=%b want 0", st_ready);
    end
    for (int i = 1; i < 5; i++) begin
      drain_one(a, sz, sb, d, to);
      tests++;
      if (to || {a, d} !== {32'h100 + 32'(4 * i), 32'hA0 + 32'(i)}) begin
        fails++;
        $display("FAIL full_order%0d: to=%b addr=%h wd=%h", i, to, a, d);
      end
    end
  endtask

  task automatic test_conflict();
    logic [31:0] a, d;
    logic [1:0] sz;
    logic [3:0] sb;
    bit to;
    push(SW, 32'h3004, 32'hDEAD_BEEF);
    ld_check_valid = 1; ld_check_addr = 32'h3006; #1;
    tests++;
    if (ld_conflict !== 1'b1) begin
      fails++; $display("FAIL conflict_hit: got %b want 1", ld_conflict);
    end
    ld_check_addr = 32'h3008; #1;
    tests++;
    if (ld_conflict !== 1'b0) begin
      fails++; $display("FAIL conflict_miss: got %b want 0", ld_conflict);
    end
    ld_check_addr = 32'h3006;
    drain_one(a, sz, sb, d, to);
    tests++;
    if (to || ld_conflict !== 1'b0) begin
      fails++; $display("FAIL conflict_drained: to=%b got %b want 0",
                        to, ld_conflict);
    end
    ld_check_valid = 0;
  endtask

  task automatic test_flush();
    flush = 1;
    push(SW, 32'h5000, 32'h1);
    flush = 0;
    tests++;
    if (sb_empty !== 1'b1) begin
      fails++; $display("FAIL flush_nopush: empty=%b want 1", sb_empty);
    end
    tick();
    tests++;
    if ({data_sram_req, st_ready} !== 2'b01) begin
      fails++; $display("FAIL flush_idle: req/rdy=%b want 01",
                        {data_sram_req, st_ready});
    end
  endtask

  task automatic test_reset_mid();
    push(SW, 32'h7000, 32'h77);
    tick();
    data_sram_addr_ok = 1; tick(); data_sram_addr_ok = 0;
    rst = 1; tick(); rst = 0;
    data_sram_data_ok = 1; tick(); data_sram_data_ok = 0;
    tests++;
    if ({data_sram_req, sb_empty, st_ready, data_sram_addr}
        !== {3'b011, 32'h0}) begin
      fails++; $display("FAIL rst_mid: req=%b emp=%b rdy=%b addr=%h",
                        data_sram_req, sb_empty, st_ready, data_sram_addr);
    end
    tick();
    tests++;
    if ({data_sram_req, sb_empty} !== 2'b01) begin
      fails++; $display("FAIL rst_mid_idle: req/emp=%b want 01",
                        {data_sram_req, sb_empty});
    end
  endtask

`ifdef STORE_MERGE_EN
  task automatic test_merge();
    logic [31:0] a, d;
    logic [1:0] sz;
    logic [3:0] sb;
    bit to;
    push(SW, 32'h6000, 32'h66);
    push(SB, 32'h4000, 32'h11);
    push(SB, 32'h4001, 32'h22);
    drain_one(a, sz, sb, d, to);
    drain_one(a, sz, sb, d, to);
    tests++;
    if (to || {a, sz, sb, d[15:0]} !== {32'h4000, 2'd2, 4'b0011, 16'h2211}) begin
      fails++;
      $display("FAIL merge: to=%b addr=%h sz=%0d strb=%b wd=%h", to, a, sz, sb, d);
    end
    tick();
    tests++;
    if (sb_empty !== 1'b1) begin
      fails++; $display("FAIL merge_single: empty=%b want 1", sb_empty);
    end
  endtask
`endif

  task automatic test_random();
    int ph, nph, k;
    bit push_m, pop_m, conf;
    ref_t e;
    ph = 0;
    mq.delete();
    for (int c = 0; c < 800; c++) begin
      st_valid = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 5);
      st_op = (k == 5) ? 5'b0 : 5'(1 << k);
      st_addr = 32'h5000 + $urandom_range(0, 31);
      st_data = $urandom;
      flush = ($urandom_range(0, 9) == 0);
      data_sram_addr_ok = ($urandom_range(0, 2) == 0);
      data_sram_data_ok = ($urandom_range(0, 2) == 0);
      ld_check_valid = 1'($urandom_range(0, 1));
      ld_check_addr = 32'h5000 + $urandom_range(0, 31);
      #1;
      conf = 0;
      foreach (mq[i]) if (mq[i].addr[31:2] == ld_check_addr[31:2]) conf = 1;
      conf = conf & ld_check_valid;
      tests++;
      if ({data_sram_req, st_ready, sb_empty, stallreq_for_store, ld_conflict}
          !== {ph == 1, mq.size() < 4, mq.size() == 0 && ph == 0,
               st_valid && mq.size() == 4, conf}) begin
        fails++;
        $display("FAIL rand_ctl c=%0d: req/rdy/emp/stall/conf=%b ph=%0d n=%0d",
                 c, {data_sram_req, st_ready, sb_empty, stallreq_for_store,
                 ld_conflict}, ph, mq.size());
      end
      if (ph == 1) begin
        tests++;
        if ({data_sram_addr, data_sram_size, data_sram_wstrb, data_sram_wdata}
            !== {mq[0].addr, mq[0].size, mq[0].strb, mq[0].data}) begin
          fails++;
          $display("FAIL rand_req c=%0d: addr=%h/%h strb=%b/%b wd=%h/%h",
                   c, data_sram_addr, mq[0].addr, data_sram_wstrb,
                   mq[0].strb, data_sram_wdata, mq[0].data);
        end
      end
      push_m = st_valid && !flush && st_op != 0 && mq.size() < 4;
      pop_m = (ph == 2) && data_sram_data_ok;
      e = ref_align(st_op, st_addr, st_data);
      if (ph == 0) nph = (mq.size() != 0) ? 1 : 0;
      else if (ph == 1) nph = data_sram_addr_ok ? 2 : 1;
      else if (pop_m) nph = (mq.size() - 1 + int'(push_m) != 0) ? 1 : 0;
      else nph = 2;
      tick();
      if (pop_m) void'(mq.pop_front());
      if (push_m) mq.push_back(e);
      ph = nph;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sb();
    test_swl_swr();
    test_full();
    test_conflict();
    test_flush();
    test_reset_mid();
`ifdef STORE_MERGE_EN
    test_merge();
`else
    test_random();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
